// File: rtl/gnt_collector.sv
// gnt_collector
//   Requester-side front end for a registered grant generator.
//   - Per-lane request pulses are OR-ed into a pending bitmap.
//   - A snapshot of that bitmap is held on req_out for one round.
//   - The returning grant is checked and encoded to a lane index.
//   - The index is buffered in a small FIFO toward a valid/ready consumer.
//   - A pending bit is retired only when its grant is accepted.
//
// Optional feature, selected by the macro GNT_CHECK_EN:
//   defined   : accept only a one-hot gnt_in that lies inside req_out;
//               any other nonzero gnt_in is rejected and sets sticky err.
//   undefined : accept the lowest set bit of (gnt_in & req_out);
//               an empty AND is a silent reject; err is tied to 0.
//
// Ports:
//   clk        rising-edge clock for all state
//   rst_n      asynchronous active-low reset
//   req_in     [WIDTH] request set pulses
//   req_out    [WIDTH] held request vector to the grant generator
//   gnt_in     [WIDTH] grant vector from the grant generator
//   out_valid  FIFO head valid
//   out_ready  consumer accepts the head when out_valid & out_ready
//   out_idx    [IDXW] lane index at the FIFO head
//   pend       [WIDTH] current pending bitmap
//   fifo_cnt   FIFO occupancy, 0..DEPTH
//   busy       FSM is not in IDLE
//   err        sticky protocol error (GNT_CHECK_EN only)
//   tmo        sticky timeout flag
module gnt_collector #(
  parameter int WIDTH   = 256,
  parameter int IDXW    = $clog2(WIDTH),
  parameter int DEPTH   = 4,
  parameter int LAT     = 2,
  parameter int TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         req_in,
  output logic [WIDTH-1:0]         req_out,
  input  logic [WIDTH-1:0]         gnt_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [IDXW-1:0]          out_idx,
  output logic [WIDTH-1:0]         pend,
  output logic [$clog2(DEPTH):0]   fifo_cnt,
  output logic                     busy,
  output logic                     err,
  output logic                     tmo
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int TW  = $clog2(TIMEOUT + 1);
  localparam int DRW = $clog2(LAT + 1) + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]       state_reg;
  logic [WIDTH-1:0] req_reg;
  logic [WIDTH-1:0] pend_reg;
  logic [WIDTH-1:0] pend_next;
  logic [TW-1:0]    timer_reg;
  logic [DRW-1:0]   drain_reg;
  logic             tmo_reg;

  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    cnt_reg;
  logic [IDXW-1:0]  mem [DEPTH];

  logic             gnt_any;
  logic             accept;
  logic [WIDTH-1:0] sel;
  logic [WIDTH-1:0] clr_mask;
  logic [IDXW-1:0]  idx_enc;
  logic             in_req;
  logic             push;
  logic             reject;
  logic             timeout;
  logic             pop;

  assign gnt_any = |gnt_in;
  assign in_req  = (state_reg == ST_REQ);

`ifdef GNT_CHECK_EN
  logic err_reg;
  logic gnt_onehot;

  // x & (x-1) clears the lowest set bit; zero result means at most one bit
  assign gnt_onehot = gnt_any && ((gnt_in & (gnt_in - WIDTH'(1))) == '0);
  assign accept     = gnt_onehot && ((gnt_in & ~req_reg) == '0);
  assign sel        = gnt_in;
`else
  logic [WIDTH-1:0] masked;

  assign masked = gnt_in & req_reg;
  // Two's-complement trick isolates the lowest set bit
  assign sel    = masked & (~masked + WIDTH'(1));
  assign accept = |masked;
`endif

  assign push    = in_req && gnt_any && accept;
  assign reject  = in_req && gnt_any && !accept;
  assign timeout = in_req && !gnt_any && (timer_reg == TW'(TIMEOUT - 1));
  assign pop     = (cnt_reg != '0) && out_ready;

  // Set wins over retire so a re-request in the retire cycle is not lost
  assign clr_mask  = push ? sel : '0;
  assign pend_next = (pend_reg & ~clr_mask) | req_in;

  // One-hot to binary; sel is one-hot whenever push is asserted
  always_comb begin
    idx_enc = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (sel[i]) begin
        idx_enc = idx_enc | IDXW'(i);
      end
    end
  end

  // Round FSM: IDLE snapshots pend, REQ waits for a grant, DRAIN flushes
  // grants still travelling through the generator pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      req_reg   <= '0;
      timer_reg <= '0;
      drain_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          req_reg <= '0;
          if ((pend_reg != '0) && (cnt_reg < CW'(DEPTH))) begin
            req_reg   <= pend_reg;
            timer_reg <= '0;
            state_reg <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (push || reject || timeout) begin
            req_reg   <= '0;
            drain_reg <= '0;
            state_reg <= ST_DRAIN;
          end else begin
            timer_reg <= timer_reg + TW'(1);
          end
        end
        ST_DRAIN: begin
          req_reg <= '0;
          if (drain_reg == DRW'(LAT)) begin
            state_reg <= ST_IDLE;
          end else begin
            drain_reg <= drain_reg + DRW'(1);
          end
        end
        default: begin
          req_reg   <= '0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_reg <= '0;
      tmo_reg  <= 1'b0;
    end else begin
      pend_reg <= pend_next;
      tmo_reg  <= tmo_reg | timeout;
    end
  end

`ifdef GNT_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_reg <= 1'b0;
    end else begin
      err_reg <= err_reg | reject;
    end
  end
  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

  // Index FIFO; push is never issued when full because IDLE only starts a
  // round with free space and the consumer can only drain it meanwhile.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
      case ({push, pop})
        2'b10:   cnt_reg <= cnt_reg + CW'(1);
        2'b01:   cnt_reg <= cnt_reg - CW'(1);
        default: cnt_reg <= cnt_reg;
      endcase
    end
  end

  // Storage has no reset; the head is masked to 0 while empty instead
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= idx_enc;
    end
  end

  assign out_valid = (cnt_reg != '0);
  assign out_idx   = out_valid ? mem[rd_ptr_reg] : '0;
  assign fifo_cnt  = cnt_reg;
  assign req_out   = req_reg;
  assign pend      = pend_reg;
  assign busy      = (state_reg != ST_IDLE);
  assign tmo       = tmo_reg;

endmodule

// File: tb/tb_gnt_collector.sv
// tb_gnt_collector
//   Directed bench for gnt_collector (WIDTH=8, DEPTH=4, LAT=2, TIMEOUT=16).
//   A small grant-generator model closes the req_out -> gnt_in loop with a
//   two-cycle latency. Expected lane indices are queued as requests are
//   issued; a monitor pops and compares on every accepted FIFO head.
//   Honours GNT_CHECK_EN the same way the design does.
module tb_gnt_collector;

  localparam int WIDTH   = 8;
  localparam int IDXW    = 3;
  localparam int DEPTH   = 4;
  localparam int LAT     = 2;
  localparam int TIMEOUT = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] req_in = '0;
  logic [WIDTH-1:0] gnt_in = '0;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] req_out;
  logic             out_valid;
  logic [IDXW-1:0]  out_idx;
  logic [WIDTH-1:0] pend;
  logic [2:0]       fifo_cnt;
  logic             busy;
  logic             err;
  logic             tmo;

  int tests = 0;
  int fails = 0;
  int exp_q[$];
  int mon_exp;

  // Grant model: 0 = lowest bit of req_out, 1 = never grant,
  // 2 = return gforce whenever req_out is nonzero
  int               gmode = 0;
  logic [WIDTH-1:0] gforce = '0;
  logic [WIDTH-1:0] gcalc;
  logic [WIDTH-1:0] gpipe [LAT];

  gnt_collector #(
    .WIDTH(WIDTH), .IDXW(IDXW), .DEPTH(DEPTH), .LAT(LAT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_in(req_in), .req_out(req_out),
    .gnt_in(gnt_in), .out_valid(out_valid), .out_ready(out_ready),
    .out_idx(out_idx), .pend(pend), .fifo_cnt(fifo_cnt), .busy(busy),
    .err(err), .tmo(tmo)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) gpipe[i] = '0;
      gnt_in = '0;
    end else begin
      case (gmode)
        0:       gcalc = req_out & (~req_out + 8'd1);
        1:       gcalc = '0;
        default: gcalc = (req_out != '0) ? gforce : '0;
      endcase
      for (int i = LAT - 1; i > 0; i--) gpipe[i] = gpipe[i-1];
      gpipe[0] = gcalc;
      gnt_in = gpipe[LAT-1];
    end
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pop: got idx %0d, expected no output", out_idx);
      end else begin
        mon_exp = exp_q.pop_front();
        $display("[TB] pop idx=%0d expected=%0d", out_idx, mon_exp);
        check("fifo_idx", 32'(out_idx), 32'(mon_exp));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] sig(input int w);
    case (w)
      0:       return 32'(busy);
      1:       return 32'(pend);
      2:       return 32'(fifo_cnt);
      3:       return 32'(tmo);
      default: return 32'(err);
    endcase
  endfunction

  // Bounded wait; an expired budget shows up as a failed comparison
  task automatic wait_for(input string name, input int w,
                          input logic [31:0] v, input int budget);
    for (int i = 0; i < budget && sig(w) !== v; i++) tick(1);
    check(name, sig(w), v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick(3);
    rst_n = 1'b1;
    tick(1);
    check("rst_req_out", 32'(req_out), 0);
    check("rst_pend", 32'(pend), 0);
    check("rst_fifo_cnt", 32'(fifo_cnt), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_idx", 32'(out_idx), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_err", 32'(err), 0);
    check("rst_tmo", 32'(tmo), 0);

    // Single request on lane 2, exact round timing
    out_ready = 1'b1;
    req_in = 8'h04;
    exp_q.push_back(2);
    tick(1);
    req_in = '0;
    check("t1_pend_set", 32'(pend), 32'h04);
    check("t1_busy_idle", 32'(busy), 0);
    tick(1);
    check("t1_req_out", 32'(req_out), 32'h04);
    check("t1_busy", 32'(busy), 1);
    tick(2);
    check("t1_pend_clr", 32'(pend), 0);
    check("t1_req_drop", 32'(req_out), 0);
    check("t1_out_valid", 32'(out_valid), 1);
    tick(1);
    check("t1_fifo_empty", 32'(fifo_cnt), 0);
    tick(1);
    check("t1_drain_busy", 32'(busy), 1);
    tick(1);
    check("t1_idle", 32'(busy), 0);

    // Two lanes, lowest granted first, consumer stalled
    out_ready = 1'b0;
    tick(2);
    req_in = 8'h81;
    exp_q.push_back(0);
    exp_q.push_back(7);
    tick(1);
    req_in = '0;
    check("t2_pend81", 32'(pend), 32'h81);
    wait_for("t2_pend80", 1, 32'h80, 20);
    wait_for("t2_pend00", 1, 32'h00, 30);
    wait_for("t2_idle", 0, 0, 10);
    check("t2_fifo_cnt", 32'(fifo_cnt), 2);
    check("t2_head", 32'(out_idx), 0);
    out_ready = 1'b1;
    wait_for("t2_fifo_drain", 2, 0, 10);

    // FIFO full back-pressure with five single-lane requests
    out_ready = 1'b0;
    for (int lane = 1; lane <= 5; lane++) begin
      req_in = 8'(1 << lane);
      exp_q.push_back(lane);
      tick(1);
    end
    req_in = '0;
    wait_for("t3_fifo_full", 2, 4, 100);
    wait_for("t3_idle", 0, 0, 10);
    tick(5);
    check("t3_stall_busy", 32'(busy), 0);
    check("t3_stall_req", 32'(req_out), 0);
    check("t3_stall_pend", 32'(pend), 32'h20);
    check("t3_stall_cnt", 32'(fifo_cnt), 4);
    out_ready = 1'b1;
    wait_for("t3_pend_done", 1, 0, 40);
    wait_for("t3_idle2", 0, 0, 10);
    wait_for("t3_fifo_drain", 2, 0, 10);

    // Timeout: no grant returned while in REQ
    gmode = 1;
    req_in = 8'h10;
    exp_q.push_back(4);
    tick(1);
    req_in = '0;
    wait_for("t4_busy", 0, 1, 5);
    tick(10);
    check("t4_tmo_early", 32'(tmo), 0);
    check("t4_req_held", 32'(req_out), 32'h10);
    wait_for("t4_tmo", 3, 1, 20);
    check("t4_req_drop", 32'(req_out), 0);
    check("t4_pend_kept", 32'(pend), 32'h10);
    gmode = 0;
    wait_for("t4_reissue", 1, 0, 40);
    wait_for("t4_idle", 0, 0, 10);

    // Two-hot grant
    gforce = 8'h06;
    gmode = 2;
    req_in = 8'h06;
    exp_q.push_back(1);
    exp_q.push_back(2);
    tick(1);
    req_in = '0;
`ifdef GNT_CHECK_EN
    wait_for("t5_err", 4, 1, 20);
    check("t5_pend_kept", 32'(pend), 32'h06);
    check("t5_no_push", 32'(fifo_cnt), 0);
    check("t5_req_drop", 32'(req_out), 0);
`else
    wait_for("t5_pend04", 1, 32'h04, 20);
    check("t5_err_zero", 32'(err), 0);
`endif
    gmode = 0;
    wait_for("t5_pend_done", 1, 0, 40);
    wait_for("t5_idle", 0, 0, 10);
    wait_for("t5_fifo_drain", 2, 0, 10);

    // Retire and re-request lane 3 on the same edge
    tick(2);
    req_in = 8'h08;
    exp_q.push_back(3);
    exp_q.push_back(3);
    tick(1);
    req_in = '0;
    tick(1);
    check("t6_req_out", 32'(req_out), 32'h08);
    tick(1);
    req_in = 8'h08;
    tick(1);
    req_in = '0;
    check("t6_set_wins", 32'(pend), 32'h08);
    check("t6_drain", 32'(busy), 1);
    wait_for("t6_pend_done", 1, 0, 30);
    wait_for("t6_idle", 0, 0, 10);

    // Asynchronous reset in the middle of REQ
    gmode = 1;
    req_in = 8'h01;
    tick(1);
    req_in = '0;
    wait_for("t7_busy", 0, 1, 5);
    tick(3);
    check("t7_req_before", 32'(req_out), 32'h01);
    #2;
    rst_n = 1'b0;
    #1;
    check("t7_req_out", 32'(req_out), 0);
    check("t7_pend", 32'(pend), 0);
    check("t7_busy", 32'(busy), 0);
    check("t7_fifo_cnt", 32'(fifo_cnt), 0);
    check("t7_out_valid", 32'(out_valid), 0);
    check("t7_tmo", 32'(tmo), 0);
    check("t7_err", 32'(err), 0);
    tick(2);
    rst_n = 1'b1;
    gmode = 0;
    tick(3);
    check("t7_idle_after", 32'(busy), 0);

    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
